// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad geometry, key code type and row/column-to-key mapping
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = 12;
    localparam int KEY_STAR = 10;
    localparam int KEY_HASH = 11;

    typedef logic [3:0] key_code_t;

    // Rows 0-2 hold digits 1-9; the bottom row is '*', '0', '#'.
    function automatic key_code_t key_index(input logic [1:0] row, input logic [1:0] col);
        if (row == 2'd3) begin
            case (col)
                2'd0:    return key_code_t'(KEY_STAR);
                2'd1:    return key_code_t'(0);
                default: return key_code_t'(KEY_HASH);
            endcase
        end
        return ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key frame-based debouncer with a restartable agreement window
module key_debounce #(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic frame_done,
    input  logic frame_valid,
    input  logic raw,
    output logic stable
);

    localparam int CW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

    logic [CW-1:0] cnt_q;
    logic          stable_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (frame_done && frame_valid) begin
            if (raw == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= raw;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - 4x3 keypad row scanner with per-key debounce and press events
// Optional: KEYPAD_GHOST_REJECT_EN discards frames with more than one raw key set.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 2500,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_COLS-1:0] KP_COL,
    output logic [NUM_ROWS-1:0] KP_ROW,
    output logic [9:0]          Keypad,
    output logic                KeypadHash,
    output logic                KeypadStar,
    output logic                KEY_PRESS,
    output key_code_t           KEY_CODE
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SCAN_DIV - 1);

    logic [NUM_COLS-1:0] col_s1_q, col_s2_q;
    logic [PW-1:0]       phase_q;
    logic [1:0]          row_q;
    logic [NUM_KEYS-1:0] raw_q, raw_d, stable, prev, rose;
    logic [9:0]          keypad_q;
    logic                hash_q, star_q, press_q;
    key_code_t           code_q, code_d;
    logic                sample, frame_done, frame_valid;

    assign sample     = (phase_q == PHASE_LAST);
    assign frame_done = sample && (row_q == 2'd3);
    assign KP_ROW     = NUM_ROWS'(1) << row_q;

    // raw_d already contains the row being sampled, so the debouncers see the full frame
    always_comb begin
        raw_d = raw_q;
        if (sample) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                raw_d[key_index(row_q, 2'(c))] = col_s2_q[c];
            end
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    assign frame_valid = ((raw_d & (raw_d - NUM_KEYS'(1))) == '0);
`else
    assign frame_valid = 1'b1;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col_s1_q <= '0;
            col_s2_q <= '0;
            phase_q  <= '0;
            row_q    <= '0;
            raw_q    <= '0;
        end else begin
            col_s1_q <= KP_COL;
            col_s2_q <= col_s1_q;
            raw_q    <= raw_d;
            if (sample) begin
                phase_q <= '0;
                row_q   <= row_q + 2'd1;
            end else begin
                phase_q <= phase_q + PW'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
        ) u_debounce (
            .CLK        (CLK),
            .RST        (RST),
            .frame_done (frame_done),
            .frame_valid(frame_valid),
            .raw        (raw_d[k]),
            .stable     (stable[k])
        );
    end

    assign prev = {hash_q, star_q, keypad_q};
    assign rose = stable & ~prev;

    always_comb begin
        code_d = code_q;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (rose[k]) code_d = key_code_t'(k);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            keypad_q <= '0;
            hash_q   <= 1'b0;
            star_q   <= 1'b0;
            press_q  <= 1'b0;
            code_q   <= '0;
        end else begin
            keypad_q <= stable[9:0];
            hash_q   <= stable[KEY_HASH];
            star_q   <= stable[KEY_STAR];
            press_q  <= |rose;
            code_q   <= code_d;
        end
    end

    assign Keypad     = keypad_q;
    assign KeypadHash = hash_q;
    assign KeypadStar = star_q;
    assign KEY_PRESS  = press_q;
    assign KEY_CODE   = code_q;

endmodule
